// File: rtl/misr_compactor.sv
// Multiple-input signature register for BIST response compaction with pattern counting and golden compare.
// Optional build macro MISR_XMASK_EN adds an x_mask input that clears unknown bits of the folded word.
module misr_compactor #(
  parameter int WIDTH = 10,
  parameter int DIN_W = 18,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] poly,
  input  logic [WIDTH-1:0] seed,
  input  logic [CNT_W-1:0] n_patterns,
  input  logic             d_valid,
  input  logic [DIN_W-1:0] d_in,
`ifdef MISR_XMASK_EN
  input  logic [WIDTH-1:0] x_mask,
`endif
  input  logic [WIDTH-1:0] expected,
  output logic [WIDTH-1:0] sig,
  output logic             busy,
  output logic             done,
  output logic             pass
);

  localparam int NSLICE = (DIN_W + WIDTH - 1) / WIDTH;
  localparam int PAD_W  = NSLICE * WIDTH;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1'b1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state_r;
  logic [WIDTH-1:0] sig_r;
  logic [CNT_W-1:0] count_r;
  logic             busy_r;
  logic             done_r;
  logic             pass_r;

  logic [WIDTH-1:0] fold_s;
  logic [WIDTH-1:0] fold_masked_s;
  logic [WIDTH-1:0] sig_next_s;

  // Zero-pad the response to a whole number of slices and XOR the slices together.
  function automatic logic [WIDTH-1:0] fold_word(input logic [DIN_W-1:0] d);
    logic [PAD_W-1:0] pad;
    logic [WIDTH-1:0] acc;
    pad = '0;
    pad[DIN_W-1:0] = d;
    acc = '0;
    for (int k = 0; k < NSLICE; k++) begin
      acc = acc ^ pad[k*WIDTH +: WIDTH];
    end
    return acc;
  endfunction

  // One MISR shift: right shift, feedback from bit 0 through the polynomial, inject folded data.
  function automatic logic [WIDTH-1:0] misr_step(input logic [WIDTH-1:0] s,
                                                 input logic [WIDTH-1:0] p,
                                                 input logic [WIDTH-1:0] f);
    logic [WIDTH-1:0] nxt;
    nxt = ({WIDTH{s[0]}} & p) ^ f ^ {1'b0, s[WIDTH-1:1]};
    return nxt;
  endfunction

  // Fold, optionally mask, and compute the candidate next signature.
  always_comb begin
    fold_s = fold_word(d_in);
`ifdef MISR_XMASK_EN
    fold_masked_s = fold_s & ~x_mask;
`else
    fold_masked_s = fold_s;
`endif
    sig_next_s = misr_step(sig_r, poly, fold_masked_s);
  end

  // Control FSM with registered signature, counter and status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      sig_r   <= '0;
      count_r <= '0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      pass_r  <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            sig_r   <= seed;
            count_r <= n_patterns;
            if (n_patterns == '0) begin
              // Empty run: compare the seed itself against the golden value.
              state_r <= ST_DONE;
              busy_r  <= 1'b0;
              done_r  <= 1'b1;
              pass_r  <= (seed == expected);
            end else begin
              state_r <= ST_RUN;
              busy_r  <= 1'b1;
              done_r  <= 1'b0;
              pass_r  <= 1'b0;
            end
          end else begin
            state_r <= state_r;
          end
        end
        ST_RUN: begin
          if (d_valid) begin
            sig_r   <= sig_next_s;
            count_r <= count_r - CNT_ONE;
            if (count_r == CNT_ONE) begin
              state_r <= ST_DONE;
              busy_r  <= 1'b0;
              done_r  <= 1'b1;
              pass_r  <= (sig_next_s == expected);
            end else begin
              state_r <= ST_RUN;
            end
          end else begin
            state_r <= ST_RUN;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
          pass_r  <= 1'b0;
        end
      endcase
    end
  end

  assign sig  = sig_r;
  assign busy = busy_r;
  assign done = done_r;
  assign pass = pass_r;

endmodule

// File: tb/tb_misr_compactor.sv
// Directed and randomized checks of misr_compactor against a behavioural signature model.
module tb_misr_compactor;

  localparam int W  = 10;
  localparam int DW = 18;
  localparam int CW = 16;

  logic          clk;
  logic          rst;
  logic          start;
  logic [W-1:0]  poly;
  logic [W-1:0]  seed;
  logic [CW-1:0] n_patterns;
  logic          d_valid;
  logic [DW-1:0] d_in;
  logic [W-1:0]  x_mask;
  logic [W-1:0]  expected;
  logic [W-1:0]  sig;
  logic          busy;
  logic          done;
  logic          pass;

  int n_assert = 0;
  int n_fail   = 0;

  // Behavioural model state
  logic [W-1:0] m_sig;
  int           m_left;
  logic         m_busy;
  logic         m_done;
  logic         m_pass;
  logic [W-1:0] saved;

  misr_compactor #(.WIDTH(W), .DIN_W(DW), .CNT_W(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .poly       (poly),
    .seed       (seed),
    .n_patterns (n_patterns),
    .d_valid    (d_valid),
    .d_in       (d_in),
`ifdef MISR_XMASK_EN
    .x_mask     (x_mask),
`endif
    .expected   (expected),
    .sig        (sig),
    .busy       (busy),
    .done       (done),
    .pass       (pass)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] ref_fold(input logic [DW-1:0] d, input logic [W-1:0] xm);
    int unsigned v;
    int unsigned f;
    v = 32'(d);
    f = 0;
    while (v != 0) begin
      f = f ^ (v % 1024);
      v = v / 1024;
    end
`ifdef MISR_XMASK_EN
    f = f & ~32'(xm);
`else
    f = f + 0 * 32'(xm);
`endif
    return f[W-1:0];
  endfunction

  function automatic logic [W-1:0] ref_step(input logic [W-1:0] s, input logic [W-1:0] p,
                                            input logic [W-1:0] f);
    logic [W-1:0] n;
    for (int i = 0; i < W; i++) begin
      if (i == W - 1) n[i] = (s[0] & p[i]) ^ f[i];
      else            n[i] = (s[0] & p[i]) ^ f[i] ^ s[i+1];
    end
    return n;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance the model on the current inputs, clock the DUT, then compare all outputs.
  task automatic tick();
    if (rst) begin
      m_sig = '0; m_left = 0; m_busy = 1'b0; m_done = 1'b0; m_pass = 1'b0;
    end else if (!m_busy) begin
      if (start) begin
        m_sig  = seed;
        m_left = int'(n_patterns);
        if (m_left == 0) begin
          m_done = 1'b1; m_busy = 1'b0; m_pass = (seed == expected);
        end else begin
          m_done = 1'b0; m_busy = 1'b1; m_pass = 1'b0;
        end
      end
    end else if (d_valid) begin
      m_sig  = ref_step(m_sig, poly, ref_fold(d_in, x_mask));
      m_left = m_left - 1;
      if (m_left == 0) begin
        m_busy = 1'b0; m_done = 1'b1; m_pass = (m_sig == expected);
      end
    end
    @(posedge clk);
    #1;
    check("model_sig",  32'(sig),  32'(m_sig));
    check("model_busy", 32'(busy), 32'(m_busy));
    check("model_done", 32'(done), 32'(m_done));
    check("model_pass", 32'(pass), 32'(m_pass));
  endtask

  task automatic run1(input logic [W-1:0] s, input logic [W-1:0] p, input logic [DW-1:0] d,
                      input logic [W-1:0] e);
    seed = s; poly = p; n_patterns = 16'd1; expected = e;
    start = 1'b1; tick(); start = 1'b0;
    d_in = d; d_valid = 1'b1; tick(); d_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; poly = '0; seed = '0; n_patterns = '0;
    d_valid = 1'b0; d_in = '0; x_mask = '0; expected = '0;
    m_sig = '0; m_left = 0; m_busy = 1'b0; m_done = 1'b0; m_pass = 1'b0;
    tick(); tick();
    check("reset_sig", 32'(sig), 32'h0);
    check("reset_busy", 32'(busy), 32'h0);
    rst = 1'b0;
    tick();

    // Reset in the middle of a run overrides start and d_valid
    seed = 10'h0AB; poly = 10'h211; n_patterns = 16'd5; start = 1'b1; tick(); start = 1'b0;
    d_valid = 1'b1; d_in = 18'h12345; tick(); tick();
    rst = 1'b1; start = 1'b1; tick(); tick();
    rst = 1'b0; start = 1'b0; d_valid = 1'b0;
    check("midrun_rst_sig",  32'(sig),  32'h0);
    check("midrun_rst_busy", 32'(busy), 32'h0);
    check("midrun_rst_done", 32'(done), 32'h0);
    check("midrun_rst_pass", 32'(pass), 32'h0);
    tick();

    // Lowest data bit goes straight into sig[0]
    run1(10'h000, 10'h000, 18'h00001, 10'h001);
    check("lsb_done", 32'(done), 32'h1);
    check("lsb_sig",  32'(sig),  32'h001);
    check("lsb_pass", 32'(pass), 32'h1);

    // Upper slice folds onto the low bits; restart straight from DONE
    run1(10'h000, 10'h000, 18'h3FC00, 10'h000);
    check("fold_sig",  32'(sig),  32'h0FF);
    check("fold_pass", 32'(pass), 32'h0);

    // Full feedback with no data
    run1(10'h001, 10'h3FF, 18'h00000, 10'h3FE);
    check("fb_sig",  32'(sig),  32'h3FF);
    check("fb_done", 32'(done), 32'h1);
    check("fb_pass", 32'(pass), 32'h0);

    // Zero-length run reports the seed and ignores data afterwards
    seed = 10'h155; n_patterns = 16'd0; expected = 10'h155; start = 1'b1; tick(); start = 1'b0;
    check("n0_done", 32'(done), 32'h1);
    check("n0_busy", 32'(busy), 32'h0);
    check("n0_sig",  32'(sig),  32'h155);
    check("n0_pass", 32'(pass), 32'h1);
    d_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      d_in = DW'($urandom); tick();
    end
    d_valid = 1'b0;
    check("n0_hold_sig", 32'(sig), 32'h155);

    // Three patterns with a gap and an ignored start mid-run
    seed = W'($urandom); poly = W'($urandom); n_patterns = 16'd3; expected = W'($urandom);
    start = 1'b1; tick(); start = 1'b0;
    d_valid = 1'b1; d_in = DW'($urandom); tick();
    d_valid = 1'b0; tick();
    start = 1'b1; seed = 10'h000; n_patterns = 16'd9; tick(); start = 1'b0;
    d_valid = 1'b1; d_in = DW'($urandom); tick();
    check("n3_busy_after2", 32'(busy), 32'h1);
    check("n3_done_after2", 32'(done), 32'h0);
    d_in = DW'($urandom); tick(); d_valid = 1'b0;
    check("n3_done_after3", 32'(done), 32'h1);
    check("n3_busy_after3", 32'(busy), 32'h0);
    tick();
    check("n3_done_hold", 32'(done), 32'h1);

`ifdef MISR_XMASK_EN
    // Fully masked data behaves like zero data
    x_mask = 10'h3FF;
    run1(10'h2C7, 10'h1A5, DW'($urandom), 10'h000);
    saved = sig;
    x_mask = 10'h000;
    run1(10'h2C7, 10'h1A5, 18'h00000, 10'h000);
    check("xmask_full", 32'(sig), 32'(saved));
`endif

    // Randomized runs with changing polynomial and stray starts
    for (int r = 0; r < 8; r++) begin
      seed = W'($urandom); poly = W'($urandom);
      n_patterns = CW'($urandom_range(0, 8));
      expected = W'($urandom);
      start = 1'b1; tick(); start = 1'b0;
      for (int c = 0; c < 80 && !m_done; c++) begin
        d_valid = ($urandom_range(0, 3) != 0);
        d_in    = DW'($urandom);
        poly    = W'($urandom);
`ifdef MISR_XMASK_EN
        x_mask  = W'($urandom);
`endif
        start   = ($urandom_range(0, 7) == 0);
        if ($urandom_range(0, 1) == 1)
          expected = ref_step(m_sig, poly, ref_fold(d_in, x_mask));
        else
          expected = W'($urandom);
        tick();
      end
      start = 1'b0; d_valid = 1'b0;
      check("rand_run_finished", 32'(done), 32'h1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
